// File: rtl/cisr_result_writer.sv
// Result writer for the CISR accumulator: clears the output-vector RAM, stores
// per-row results with completion/error tracking, and offers a registered read port.
module cisr_result_writer #(
  parameter int row_id_size      = 8,
  parameter int accumulator_size = 32,
  parameter int count_size       = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [count_size-1:0]       num_rows,
  input  logic                        write_data,
  input  logic [row_id_size-1:0]      addr_data,
  input  logic [accumulator_size-1:0] data,
  input  logic                        rd_en,
  input  logic [row_id_size-1:0]      rd_addr,
  output logic [accumulator_size-1:0] rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic [count_size-1:0]       rows_written,
  output logic                        overwrite_err,
  output logic                        range_err
);

  localparam int DEPTH = 2 ** row_id_size;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [count_size-1:0]       num_rows_q, num_rows_d;
  logic [row_id_size-1:0]      ptr_q, ptr_d;
  logic [DEPTH-1:0]            bitmap_q, bitmap_d;
  logic [count_size-1:0]       rows_written_q, rows_written_d;
  logic                        ovr_q, ovr_d;
  logic                        rng_q, rng_d;
  logic                        last_vld_q, last_vld_d;
  logic [row_id_size-1:0]      last_addr_q, last_addr_d;
  logic [accumulator_size-1:0] rd_data_q, rd_data_d;
  logic                        rd_valid_q, rd_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [accumulator_size-1:0] mem [DEPTH];
  logic                        mem_we;
  logic [row_id_size-1:0]      mem_waddr;
  logic [accumulator_size-1:0] mem_wdata;
  logic                        in_range;

  always_comb begin
    state_d        = state_q;
    num_rows_d     = num_rows_q;
    ptr_d          = ptr_q;
    bitmap_d       = bitmap_q;
    rows_written_d = rows_written_q;
    ovr_d          = ovr_q;
    rng_d          = rng_q;
    last_vld_d     = 1'b0;
    last_addr_d    = last_addr_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = addr_data;
    mem_wdata      = data;
    in_range       = count_size'(addr_data) < num_rows_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_rows_d     = num_rows;
          rows_written_d = '0;
          ovr_d          = 1'b0;
          rng_d          = 1'b0;
          ptr_d          = '0;
          state_d        = CLEAR;
        end
        // Reads are only served here, so they never collide with a RAM write.
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem[rd_addr];
        end
      end
      CLEAR: begin
        mem_we           = 1'b1;
        mem_waddr        = ptr_q;
        mem_wdata        = '0;
        bitmap_d[ptr_q]  = 1'b0;
        ptr_d            = ptr_q + row_id_size'(1);
        if (ptr_q == '1) state_d = (num_rows_q != '0) ? RUN : DONE;
      end
      RUN: begin
        if (write_data) begin
          if (!in_range) begin
            rng_d = 1'b1;
          end else begin
            mem_we      = 1'b1;
            last_vld_d  = 1'b1;
            last_addr_d = addr_data;
            if (!bitmap_q[addr_data]) begin
              bitmap_d[addr_data] = 1'b1;
              if (rows_written_q < num_rows_q)
                rows_written_d = rows_written_q + count_size'(1);
            end else if (!(last_vld_q && last_addr_q == addr_data)) begin
              // A back-to-back repeat of the same row is an upstream stall, not an error.
              ovr_d = 1'b1;
            end
          end
        end
        if (rows_written_d == num_rows_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      num_rows_q     <= '0;
      ptr_q          <= '0;
      bitmap_q       <= '0;
      rows_written_q <= '0;
      ovr_q          <= 1'b0;
      rng_q          <= 1'b0;
      last_vld_q     <= 1'b0;
      last_addr_q    <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_rows_q     <= num_rows_d;
      ptr_q          <= ptr_d;
      bitmap_q       <= bitmap_d;
      rows_written_q <= rows_written_d;
      ovr_q          <= ovr_d;
      rng_q          <= rng_d;
      last_vld_q     <= last_vld_d;
      last_addr_q    <= last_addr_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign rows_written  = rows_written_q;
  assign overwrite_err = ovr_q;
  assign range_err     = rng_q;

endmodule

// File: tb/tb_cisr_result_writer.sv
// Bench for cisr_result_writer: directed scenarios plus randomized runs checked
// against a row-level reference model; read results go through a scoreboard queue.
module tb_cisr_result_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  num_rows;
  logic        write_data;
  logic [7:0]  addr_data;
  logic [31:0] data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [8:0]  rows_written;
  logic        overwrite_err;
  logic        range_err;

  cisr_result_writer dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .write_data(write_data), .addr_data(addr_data), .data(data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .rows_written(rows_written),
    .overwrite_err(overwrite_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 clear, 2 run, 3 done.
  int          ph;
  int          mdl_n;
  int          mdl_cnt;
  bit          mdl_ovr, mdl_rng;
  bit          prev_acc;
  int          prev_addr;
  logic [31:0] mdl_mem [256];
  bit          mdl_wr [256];
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, busy, (ph == 1 || ph == 2));
    chk({tag, "_done"}, done, (ph == 3));
    chk({tag, "_rows"}, rows_written, mdl_cnt);
    chk({tag, "_ovr"}, overwrite_err, mdl_ovr);
    chk({tag, "_rng"}, range_err, mdl_rng);
  endtask

  task automatic model_reset();
    ph = 0; mdl_cnt = 0; mdl_ovr = 0; mdl_rng = 0; prev_acc = 0; last_rd = '0;
    foreach (mdl_wr[i]) mdl_wr[i] = 0;
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b0;
    tick();
    model_reset();
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    check_status(tag);
    rst = 1'b1;
  endtask

  task automatic start_run(input int n, input bit noisy);
    bit ok = 1;
    start = 1'b1; num_rows = 9'(n);
    tick();
    start = 1'b0;
    ph = 1; mdl_n = n; mdl_cnt = 0; mdl_ovr = 0; mdl_rng = 0; prev_acc = 0;
    foreach (mdl_mem[i]) begin mdl_mem[i] = '0; mdl_wr[i] = 0; end
    for (int i = 0; i < 256; i++) begin
      if (!busy || done) ok = 0;
      if (noisy) begin
        write_data = 1'($urandom); addr_data = 8'($urandom_range(0, 15));
        data = $urandom; start = 1'($urandom);
      end
      tick();
    end
    write_data = 1'b0; start = 1'b0;
    chk("clear_busy_256", ok, 1);
    ph = (n != 0) ? 2 : 3;
    check_status("post_clear");
  endtask

  task automatic step(input bit we, input int a, input logic [31:0] d);
    bit was_run = (ph == 2);
    write_data = we; addr_data = 8'(a); data = d;
    if (was_run && we) begin
      if (a >= mdl_n) mdl_rng = 1;
      else begin
        if (!mdl_wr[a]) begin mdl_wr[a] = 1; mdl_cnt++; end
        else if (!(prev_acc && prev_addr == a)) mdl_ovr = 1;
        mdl_mem[a] = d;
      end
    end
    prev_acc  = was_run && we && (a < mdl_n);
    prev_addr = a;
    if (was_run && mdl_cnt == mdl_n) ph = 3;
    tick();
    write_data = 1'b0;
    check_status("step");
  endtask

  task automatic rd(input int a);
    bit acc = (ph == 0 || ph == 3);
    rd_en = 1'b1; rd_addr = 8'(a);
    if (acc) begin exp_q.push_back(mdl_mem[a]); last_rd = mdl_mem[a]; end
    prev_acc = 0;
    tick();
    rd_en = 1'b0;
    if (!acc) chk("rd_hold", rd_data, last_rd);
  endtask

  task automatic drain();
    tick();
    chk("rd_drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every presented read result must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=%0d expected=none @%0t", rd_data, $time);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; num_rows = '0; write_data = 1'b0;
    addr_data = '0; data = '0; rd_en = 1'b0; rd_addr = '0;
    tick();
    reset_cycle("reset");

    // Basic run: out-of-order rows, readback in address order.
    start_run(4, 1'b0);
    step(1, 2, 10); step(1, 0, 20); step(1, 3, 30); step(1, 1, 40);
    for (int a = 0; a < 4; a++) rd(a);
    drain();

    // Stall repeat, true overwrite, range drop, start ignored in RUN.
    start_run(3, 1'b0);
    step(1, 1, 5); step(1, 1, 5);
    step(0, 0, 0); step(1, 1, 9);
    step(1, 7, 77);
    start = 1'b1; num_rows = 9'd0;
    step(0, 0, 0);
    start = 1'b0;
    rd(0);
    step(1, 0, 3); step(1, 2, 6);
    for (int a = 0; a < 8; a++) rd(a);
    drain();

    // Empty run goes straight to DONE.
    start_run(0, 1'b0);
    rd(5);
    drain();

    // Reset mid-RUN: flags cleared, writes ignored, RAM retained.
    start_run(4, 1'b0);
    step(1, 0, 111); step(1, 3, 333);
    reset_cycle("mid_rst");
    step(1, 1, 222); step(1, 2, 444);
    rd(0); rd(3); rd(1);
    drain();

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 12);
      start_run(n, r == 0);
      for (int k = 0; k < 40; k++) begin
        int a = $urandom_range(0, 15);
        if ($urandom_range(0, 3) == 0 && prev_acc) a = prev_addr;
        if ($urandom_range(0, 7) == 0) rd($urandom_range(0, 15));
        else step(1'($urandom), a, $urandom);
      end
      for (int a = 0; a < n; a++)
        if (ph == 2 && !mdl_wr[a]) step(1, a, $urandom);
      for (int a = 0; a < 16; a++) rd(a);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cisr_result_writer.md
Name: cisr_result_writer

Overview:
- Downstream stage of the CISR accumulator.
- Consumes its per-row result strobe (write_data, addr_data, data) and stores each row result into an on-chip output-vector RAM.
- Tracks which rows have completed, flags errors, and signals when all expected rows are written.
- Provides a registered read port so the host or next stage can drain the result vector.

Parameters:
- row_id_size, 8, width of row address; RAM depth = 2**row_id_size.
- accumulator_size, 32, width of each stored result.
- count_size, 9, width of num_rows and rows_written; must be ≥ row_id_size+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new SpMV result collection.
- num_rows  input  count_size  number of distinct rows expected; sampled when start is accepted.
- write_data  input  1  result strobe from accumulator.
- addr_data  input  row_id_size  row index of result.
- data  input  accumulator_size  row result value.
- rd_en  input  1  read request.
- rd_addr  input  row_id_size  read address.
- rd_data  output  accumulator_size  read result, 1-cycle latency.
- rd_valid  output  1  high the cycle after an accepted read.
- busy  output  1  high in CLEAR or RUN.
- done  output  1  high in DONE.
- rows_written  output  count_size  distinct rows written this run.
- overwrite_err  output  1  sticky; a row was written twice.
- range_err  output  1  sticky; addr_data ≥ latched num_rows.

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. Reset (rst low at clk edge) → IDLE.
- Reset values: rd_data=0, rd_valid=0, busy=0, done=0, rows_written=0, overwrite_err=0, range_err=0, written bitmap all 0, clear pointer 0. RAM contents undefined after reset.
- IDLE/DONE:
  - start → latch num_rows, clear rows_written and both error flags, clear pointer=0, go to CLEAR.
  - write_data ignored.
- CLEAR:
  - Each cycle write 0 to RAM[ptr], clear bitmap[ptr], ptr++.
  - After ptr = 2**row_id_size-1 is cleared: RUN if latched num_rows≠0, else DONE.
  - Duration is exactly 2**row_id_size cycles.
  - start and write_data ignored.
- RUN, on write_data=1:
  - addr_data ≥ num_rows: drop the write; set range_err.
  - bitmap[addr] = 0: RAM[addr] ← data; set bitmap[addr]; rows_written++.
  - bitmap[addr] = 1: RAM[addr] ← data (last write wins); no increment.
    - If addr_data equals the previous cycle's accepted write address and that write was strobed in the immediately preceding cycle, treat it as a stall repeat: no error.
    - Otherwise set overwrite_err.
  - When rows_written reaches num_rows (value after the update), go to DONE on the next edge.
  - start in RUN is ignored.
- Read port:
  - rd_en accepted only in IDLE or DONE.
  - rd_data ← RAM[rd_addr] and rd_valid=1 on the following cycle.
  - rd_en in CLEAR/RUN: rd_valid=0 next cycle; rd_data holds its previous value.
  - A read and a RAM write never coincide, because of the state gating.
- busy = (CLEAR or RUN); done = DONE. Both are registered state decodes.
- Reset mid-CLEAR or mid-RUN: next cycle IDLE. All flags, counters and bitmap cleared; RAM not cleared.
- rows_written saturates at num_rows; never exceeds it.

Test Plan:
- Reset, start with num_rows=4 → busy=1 for 256 CLEAR cycles, then RUN. Write rows 2,0,3,1 with data 10,20,30,40 → done=1 one cycle after the 4th write, rows_written=4. Reads of addr 0..3 return 20,40,10,30 with rd_valid one cycle later.
- num_rows=3, write row 1 with data 5 on two consecutive cycles (stall repeat) → rows_written=1, overwrite_err=0, RAM[1]=5.
- num_rows=3: write row 1 (data 5), idle one cycle, write row 1 (data 9) → overwrite_err=1, RAM[1]=9, rows_written=1.
- num_rows=2, write addr 7 → dropped, range_err=1, rows_written=0, RAM[7] reads 0 after completion.
- Start with num_rows=0 → CLEAR for 256 cycles, then DONE directly. Start pulsed during RUN → no effect.
- Assert rst low mid-RUN after 2 of 4 rows → IDLE next cycle, rows_written=0, flags 0. Writes then ignored until a new start.
